// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, FSM states, default width.
package alu_pkg;

    localparam int unsigned DATA_W_DEF = 4;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; ADD carry is the carry out, SUB carry is the borrow, ops 6/7 yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] y_o,
    output logic              carry_o
);

    always_comb begin
        y_o     = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_ADD: {carry_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
            OP_NOT: y_o = ~a_i;
            OP_SUB: {carry_o, y_o} = {1'b0, a_i} - {1'b0, b_i};
            default: begin
                y_o     = '0;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-input grant logic: round-robin on last_grant, or fixed priority to input 0.
module rr_arb2 #(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_id_i,
    output logic [1:0] gnt_o
);

    logic last_grant_q;

    // Reset to 1 so that the first tie after reset goes to requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (upd_i) begin
            last_grant_q <= upd_id_i;
        end
    end

    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                if ((FIXED_PRIORITY != 0) || last_grant_q) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = 2'b10;
                end
            end
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; one transaction at a time (IDLE->EXEC->RESP).
// Optional macro ALU_ILLEGAL_OP_CHECK_EN: ops 6/7 return result 0, carry 0, rsp_err 1.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              gid_q, gid_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              carry_q, carry_d;
    logic [1:0]        gnt;
    logic              upd;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    logic              err_q, err_d;
`endif

    rr_arb2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({req1_valid, req0_valid}),
        .upd_i    (upd),
        .upd_id_i (gid_q),
        .gnt_o    (gnt)
    );

    alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a_i     (a_q),
        .b_i     (b_q),
        .op_i    (op_q),
        .y_o     (alu_y),
        .carry_o (alu_c)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        gid_d      = gid_q;
        res_d      = res_q;
        carry_d    = carry_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        err_d      = err_q;
`endif
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        upd        = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is masked during reset: a handshake there would be discarded.
                if (!reset) begin
                    req0_ready = gnt[0];
                    req1_ready = gnt[1];
                end
                if (gnt != 2'b00) begin
                    a_d     = gnt[1] ? req1_a  : req0_a;
                    b_d     = gnt[1] ? req1_b  : req0_b;
                    op_d    = gnt[1] ? req1_op : req0_op;
                    gid_d   = gnt[1];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_y;
                carry_d = alu_c;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
                err_d   = 1'b0;
                if (!op_is_legal(op_q)) begin
                    res_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b1;
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                if (gid_q ? rsp1_ready : rsp0_ready) begin
                    upd     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            gid_q   <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gid_q   <= gid_d;
            res_q   <= res_d;
            carry_q <= carry_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rsp0_valid = (state_q == RESP) && !gid_q;
    assign rsp1_valid = (state_q == RESP) &&  gid_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign busy       = (state_q != IDLE);
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 4-bit ALU between two independent requesters (req0, req1) via per-requester valid/ready handshakes. Grants one request at a time, registers operands and op, drives the ALU, captures its result, and returns it on the granting requester's response channel. Sits between the ALU datapath and its client blocks (sequencers, test masters).

Parameters:
DATA_W, 4, operand/result width; fixed at 4 to match the ALU.
FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = req0 always wins simultaneous requests.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  request 0 accepted this cycle
req0_a  input  DATA_W  operand a
req0_b  input  DATA_W  operand b
req0_op  input  3  ALU select code
rsp0_valid  output  1  response for requester 0 available
rsp0_ready  input  1  requester 0 consumes response
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0
rsp1_valid / rsp1_ready  same as requester 0
rsp_result  output  DATA_W  registered ALU result, valid with rspN_valid
rsp_carry  output  1  registered ALU carry out
rsp_err  output  1  illegal-op flag (see Optional Feature)
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE, last_grant=1 (req0 wins first tie), reqN_ready=0, rspN_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0, busy=0.
- Op codes: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 NOT a, 5 SUB a-b; 6/7 undefined.
- FSM IDLE: reqN_ready is combinational. Asserted only for the granted requester, only when its valid=1 in IDLE. On accept, latch a, b, op and grant_id; go to EXEC. No valid: stay in IDLE.
- Arbitration: single valid wins. Both valid: with FIXED_PRIORITY=1, req0 wins. With FIXED_PRIORITY=0, the requester not equal to last_grant wins.
- FSM EXEC: latched operands drive the ALU. At the clock edge, capture alu_output into rsp_result and alu_carry_out into rsp_carry; go to RESP.
- FSM RESP: rsp{grant_id}_valid=1; rsp_result, rsp_carry and rsp_err are held stable.
  - If rsp{grant_id}_ready=1: update last_grant=grant_id and go to IDLE.
  - Otherwise hold indefinitely; no new request is accepted.
- Latency: accept at edge N -> rspN_valid high from cycle N+2. Minimum 3 cycles per transaction; no pipelining.
- A requester dropping valid before ready has no effect: nothing is latched.
- Operand changes after accept are ignored.
- Requests arriving in EXEC/RESP wait; their ready stays 0.
- Carry/result are passed unmodified from the ALU; the arbiter does no arithmetic.
- Reset in any state returns all outputs to reset values at that edge and discards any in-flight transaction.

Optional Feature:
Macro ALU_ILLEGAL_OP_CHECK_EN.
- Defined: op 6/7 is accepted normally. In EXEC, the ALU output is ignored; capture rsp_result=0, rsp_carry=0, rsp_err=1. Legal ops capture rsp_err=0.
- Undefined: rsp_err is tied 0 and op 6/7 passes straight to the ALU. Result is whatever the ALU produces.

Decomposition:
- Shared package alu_pkg:
  - 3-bit op code constants (OP_AND..OP_SUB)
  - FSM state encoding (IDLE, EXEC, RESP)
  - DATA_W default
- One natural sub-module, rr_arb2: 2-input round-robin/fixed-priority grant logic, carrying last_grant and the FIXED_PRIORITY parameter.
- The existing ALU module is instantiated inside alu_arbiter.

Test Plan:
- Single request: req0 op=3, a=F, b=F, accepted at edge N -> rsp0_valid at N+2, rsp_result=E, rsp_carry=1; rsp0_ready=1 -> back to IDLE, busy=0.
- Tie, round-robin (FIXED_PRIORITY=0): both valid continuously from reset.
  - Grants alternate req0, req1, req0.
  - req0 op=5, a=D, b=8 -> 5.
  - req1 op=2, a=E, b=1 -> F.
- Tie, fixed priority (FIXED_PRIORITY=1): both valid for 3 transactions -> all grants go to req0; req1_ready never asserted.
- Backpressure: rsp1_ready held 0 for 5 cycles after req1 op=4, a=A -> rsp1_valid and rsp_result=5 stable all 5 cycles; req0_ready=0 throughout; release -> IDLE.
- Reset mid-RESP: assert reset during RESP -> next edge: rsp*_valid=0, rsp_result=0, busy=0; first tie afterwards grants req0.
- Illegal op, with ALU_ILLEGAL_OP_CHECK_EN: req0 op=7 -> rsp_err=1, rsp_result=0. Next req0 op=0, a=F, b=F -> rsp_err=0, rsp_result=F.
